// File: rtl/stream_mux_arbiter_pkg.sv
// Shared types and constants for the stream_mux_arbiter slice.
// The STREAM_MUX_ARBITER_STATS_EN macro selects the optional transfer counter in the top.
package stream_mux_arbiter_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam int unsigned DefN   = 4;
  localparam int unsigned DefW   = 8;
  localparam int unsigned StatsW = 16;

endpackage

// File: rtl/stream_mux_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping N-1 -> 0.
// Produces a one-hot grant, its binary index and an any-request flag.
module rr_pick
  import stream_mux_arbiter_pkg::*;
#(
  parameter int unsigned N = DefN,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [IdxW-1:0] index,
  output logic            any
);

  int unsigned w_pos;

  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    w_pos = 0;
    for (int unsigned k = 0; k < N; k++) begin
      w_pos = int'(ptr) + k;
      if (w_pos >= N) w_pos = w_pos - N;
      if (!any && req[w_pos]) begin
        any          = 1'b1;
        grant[w_pos] = 1'b1;
        index        = IdxW'(w_pos);
      end
    end
  end

endmodule

// File: rtl/stream_mux_arbiter.sv
// N-input round-robin stream mux with a single registered output stage.
// Define STREAM_MUX_ARBITER_STATS_EN to add the saturating xfer_count output.
module stream_mux_arbiter
  import stream_mux_arbiter_pkg::*;
#(
  parameter int unsigned N = DefN,
  parameter int unsigned W = DefW,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      in_valid,
  input  logic [N*W-1:0]    in_data,
  output logic [N-1:0]      in_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [IdxW-1:0]   out_id,
`ifdef STREAM_MUX_ARBITER_STATS_EN
  output logic [StatsW-1:0] xfer_count,
`endif
  input  logic              out_ready
);

  state_e          r_state;
  logic [IdxW-1:0] r_ptr;
  logic [W-1:0]    r_data;
  logic [IdxW-1:0] r_id;

  logic [N-1:0]    w_grant;
  logic [IdxW-1:0] w_idx;
  logic            w_any;
  logic            w_load;
  logic            w_xfer;
  logic [IdxW-1:0] w_ptr_nxt;
  logic [W-1:0]    w_lane [N];

  for (genvar g = 0; g < int'(N); g++) begin : g_lane
    assign w_lane[g] = in_data[g*W +: W];
  end

  rr_pick #(
    .N (N)
  ) u_rr_pick (
    .req   (in_valid),
    .ptr   (r_ptr),
    .grant (w_grant),
    .index (w_idx),
    .any   (w_any)
  );

  // rst_n gates the handshake so nothing is offered while reset is held.
  assign w_load    = (r_state == EMPTY) | out_ready;
  assign in_ready  = w_grant & {N{w_load & rst_n}};
  assign w_xfer    = w_any & w_load & rst_n;
  assign w_ptr_nxt = (w_idx == IdxW'(N - 1)) ? '0 : w_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_ptr   <= '0;
      r_data  <= '0;
      r_id    <= '0;
    end else if (w_xfer) begin
      r_state <= FULL;
      r_data  <= w_lane[w_idx];
      r_id    <= w_idx;
      r_ptr   <= w_ptr_nxt;
    end else if (r_state == FULL && out_ready) begin
      r_state <= EMPTY;
    end
  end

  assign out_valid = (r_state == FULL);
  assign out_data  = r_data;
  assign out_id    = r_id;

`ifdef STREAM_MUX_ARBITER_STATS_EN
  logic [StatsW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (out_valid && out_ready && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign xfer_count = r_count;
`endif

endmodule

// File: tb/tb_stream_mux_arbiter.sv
// Scoreboard bench for stream_mux_arbiter: the driver pushes expected beats,
// a negedge monitor pops and compares each accepted output beat.
module tb_stream_mux_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  in_valid = '0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_id;
  logic        out_ready = 1'b0;
`ifdef STREAM_MUX_ARBITER_STATS_EN
  logic [15:0] xfer_count;
`endif

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b1;
  logic [7:0] lanes [4] = '{8'hA5, 8'h11, 8'h22, 8'h33};
  logic [15:0] sb [$];
  int seq [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  always #5 clk = ~clk;

  stream_mux_arbiter #(
    .N (4),
    .W (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_id     (out_id),
`ifdef STREAM_MUX_ARBITER_STATS_EN
    .xfer_count (xfer_count),
`endif
    .out_ready  (out_ready)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One cycle of stimulus; exp_id is the hand-computed grant (-1 = none).
  task automatic step(input logic [3:0] v, input logic ordy, input int exp_id, input string nm);
    logic [3:0] exp_rdy;
    in_valid  = v;
    out_ready = ordy;
    in_data   = {lanes[3], lanes[2], lanes[1], lanes[0]};
    @(negedge clk);
    exp_rdy = (exp_id >= 0) ? 4'(1 << exp_id) : 4'b0000;
    chk({nm, " in_ready"}, 32'(in_ready), 32'(exp_rdy));
    if (exp_id >= 0) sb.push_back({exp_id[7:0], lanes[exp_id]});
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic rst_pulse(input string nm);
    #2;
    rst_n    = 1'b0;
    in_valid = 4'b1111;
    #1;
    chk({nm, " out_valid"}, 32'(out_valid), 32'h0);
    chk({nm, " out_data"}, 32'(out_data), 32'h0);
    chk({nm, " out_id"}, 32'(out_id), 32'h0);
    chk({nm, " in_ready"}, 32'(in_ready), 32'h0);
    sb.delete();
    in_valid = 4'b0000;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected beat id", 32'(out_id), 32'hFFFF);
      end else begin
        logic [15:0] e;
        e = sb.pop_front();
        chk("beat id", 32'(out_id), 32'(e[15:8]));
        chk("beat data", 32'(out_data), 32'(e[7:0]));
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    rst_pulse("reset");

    // Single requester, one-cycle latency.
    step(4'b0001, 1'b1, 0, "t1 fill");
    chk("t1 out_valid after 1", 32'(out_valid), 32'h1);
    step(4'b0000, 1'b1, -1, "t1 drain");
    chk("t1 empty", 32'(out_valid), 32'h0);

    // All valid: rotating grants, back to back.
    rst_pulse("t2 reset");
    for (int i = 0; i < 8; i++) step(4'b1111, 1'b1, seq[i], "t2 stream");
    step(4'b0000, 1'b1, -1, "t2 drain");
    chk("t2 empty", 32'(out_valid), 32'h0);

    // Backpressure holds the output and blocks grants.
    lanes[0] = 8'h3C;
    step(4'b0001, 1'b1, 0, "t3 fill");
    for (int i = 0; i < 5; i++) step(4'b0110, 1'b0, -1, "t3 hold");
    chk("t3 hold valid", 32'(out_valid), 32'h1);
    chk("t3 hold data", 32'(out_data), 32'h3C);
    chk("t3 hold id", 32'(out_id), 32'h0);
    step(4'b0110, 1'b1, 1, "t3 release");
    step(4'b0000, 1'b1, -1, "t3 drain");

    // ptr=2 with only 0,1 valid wraps to 0; idle cycles keep ptr.
    step(4'b0011, 1'b1, 0, "t4 wrap");
    step(4'b0011, 1'b1, 1, "t4 next");
    step(4'b0000, 1'b1, -1, "t4 drain");
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b1, -1, "t4 idle");
    step(4'b1111, 1'b1, 2, "t4 after idle");
    step(4'b0000, 1'b1, -1, "t4 drain2");

    // Reset while FULL discards data and restarts search at 0.
    step(4'b0010, 1'b0, 1, "t5 fill");
    chk("t5 full", 32'(out_valid), 32'h1);
    rst_pulse("t5 reset");
    step(4'b1000, 1'b1, 3, "t5 req3");
    step(4'b0000, 1'b1, -1, "t5 drain");
    step(4'b0100, 1'b0, 2, "t5 fill2");
    rst_pulse("t5 reset2");
    step(4'b1010, 1'b1, 1, "t5 from0");
    step(4'b0000, 1'b1, -1, "t5 drain2");
    chk("scoreboard empty", 32'(sb.size()), 32'h0);

`ifdef STREAM_MUX_ARBITER_STATS_EN
    mon_en = 1'b0;
    rst_pulse("stats reset");
    chk("stats zero", 32'(xfer_count), 32'h0);
    in_valid  = 4'b0001;
    out_ready = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    chk("stats saturate", 32'(xfer_count), 32'hFFFF);
    in_valid = 4'b0000;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
